// File: rtl/reverse_bits_pkg.sv
// Shared constants and helpers for the bit-reversal scheduler.
package reverse_bits_pkg;

  localparam int unsigned DATA_W_DEF = 32;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  function automatic int unsigned calc_steps(input int unsigned data_w, input int unsigned bpc);
    return data_w / bpc;
  endfunction

  function automatic int unsigned calc_id_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/reverse_bits_if.sv
// Request fan-in and response channel between clients and the reversal scheduler.
interface reverse_bits_if
  import reverse_bits_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned ID_W    = calc_id_w(NUM_REQ)
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [DATA_W-1:0]         rsp_data;
  logic                      rsp_palindrome;
  logic [ID_W-1:0]           rsp_id;

  modport master (
    output req_valid, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_palindrome, rsp_id
  );

  modport slave (
    input  req_valid, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_palindrome, rsp_id
  );
endinterface

// File: rtl/reverse_bits_engine.sv
// Iterative bit reverser: BITS_PER_CYCLE source LSBs enter the result per step, plus palindrome compare.
module reverse_bits_engine
  import reverse_bits_pkg::*;
#(
  parameter int unsigned DATA_W         = DATA_W_DEF,
  parameter int unsigned BITS_PER_CYCLE = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] src,
  output logic              done_c,
  output logic [DATA_W-1:0] result,
  output logic              palindrome
);
  localparam int unsigned STEPS = calc_steps(DATA_W, BITS_PER_CYCLE);
  localparam int unsigned CNT_W = $clog2(STEPS + 1);

  if (DATA_W % BITS_PER_CYCLE != 0) begin : g_bad_cfg
    $error("DATA_W must be a multiple of BITS_PER_CYCLE");
  end

  logic [DATA_W-1:0]         src_q;
  logic [DATA_W-1:0]         shift_q;
  logic [DATA_W-1:0]         result_next;
  logic [BITS_PER_CYCLE-1:0] chunk_rev;
  logic [CNT_W-1:0]          cnt_q;
  logic                      active_q;

  // Lowest remaining source bit lands highest in the appended chunk
  always_comb begin
    chunk_rev = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      chunk_rev[i] = shift_q[BITS_PER_CYCLE-1-i];
    end
    result_next = (result << BITS_PER_CYCLE) | DATA_W'(chunk_rev);
  end

  assign done_c = active_q && (cnt_q == CNT_W'(STEPS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_q      <= '0;
      shift_q    <= '0;
      result     <= '0;
      palindrome <= 1'b0;
      cnt_q      <= '0;
      active_q   <= 1'b0;
    end else if (start) begin
      src_q      <= src;
      shift_q    <= src;
      result     <= '0;
      palindrome <= 1'b0;
      cnt_q      <= '0;
      active_q   <= 1'b1;
    end else if (active_q) begin
      result  <= result_next;
      shift_q <= shift_q >> BITS_PER_CYCLE;
      cnt_q   <= cnt_q + CNT_W'(1);
      if (done_c) begin
        active_q   <= 1'b0;
        palindrome <= (result_next == src_q);
      end
    end
  end

endmodule

// File: rtl/reverse_bits_scheduler.sv
// Round-robin arbitration of NUM_REQ clients onto one shared iterative bit-reversal engine.
module reverse_bits_scheduler
  import reverse_bits_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned DATA_W         = DATA_W_DEF,
  parameter int unsigned BITS_PER_CYCLE = 4,
  parameter int unsigned ID_W           = calc_id_w(NUM_REQ)
) (
  input  logic          clk,
  input  logic          rst_n,
  reverse_bits_if.slave bus,
  output logic          busy
);
  logic [1:0]             state_q, state_next;
  logic [ID_W-1:0]        rr_ptr_q, rr_ptr_next;
  logic [ID_W-1:0]        id_q, id_next;
  logic [ID_W-1:0]        grant_idx;
  logic                   grant_valid;
  logic [2*NUM_REQ-1:0]   dbl;
  logic [NUM_REQ-1:0]     rot;
  logic [NUM_REQ-1:0]     ready_c;
  int unsigned            off;
  int unsigned            sum;
  logic                   start_c;
  logic [DATA_W-1:0]      src_c;
  logic                   eng_done_c;
  logic [DATA_W-1:0]      eng_result;
  logic                   eng_pal;
  logic                   rsp_valid_q;
  logic                   busy_q;

  // Rotate requests so rr_ptr sits at bit 0, pick the lowest set bit, rotate back
  always_comb begin
    dbl         = {bus.req_valid, bus.req_valid} >> rr_ptr_q;
    rot         = dbl[NUM_REQ-1:0];
    grant_valid = |rot;
    off         = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot[k]) off = 32'(k);
    end
    sum = 32'(rr_ptr_q) + off;
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    grant_idx = ID_W'(sum);
    src_c = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == ID_W'(i)) src_c = bus.req_data[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    state_next  = state_q;
    rr_ptr_next = rr_ptr_q;
    id_next     = id_q;
    start_c     = 1'b0;
    ready_c     = '0;
    case (state_q)
      ST_IDLE: begin
        if (grant_valid) begin
          for (int i = 0; i < NUM_REQ; i++) begin
            ready_c[i] = (grant_idx == ID_W'(i));
          end
          start_c     = 1'b1;
          id_next     = grant_idx;
          rr_ptr_next = (32'(grant_idx) + 1 >= NUM_REQ) ? '0 : grant_idx + ID_W'(1);
          state_next  = ST_BUSY;
        end
      end
      ST_BUSY: if (eng_done_c) state_next = ST_DONE;
      ST_DONE: if (bus.rsp_ready) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      id_q        <= '0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_next;
      rr_ptr_q    <= rr_ptr_next;
      id_q        <= id_next;
      rsp_valid_q <= (state_next == ST_DONE);
      busy_q      <= (state_next != ST_IDLE);
    end
  end

  reverse_bits_engine #(
    .DATA_W        (DATA_W),
    .BITS_PER_CYCLE(BITS_PER_CYCLE)
  ) u_engine (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start_c),
    .src       (src_c),
    .done_c    (eng_done_c),
    .result    (eng_result),
    .palindrome(eng_pal)
  );

  // Response fields are masked to zero whenever no result is being offered
  assign bus.req_ready      = ready_c;
  assign bus.rsp_valid      = rsp_valid_q;
  assign bus.rsp_data       = rsp_valid_q ? eng_result : '0;
  assign bus.rsp_palindrome = rsp_valid_q & eng_pal;
  assign bus.rsp_id         = rsp_valid_q ? id_q : '0;
  assign busy               = busy_q;

endmodule

// File: tb/tb_reverse_bits_scheduler.sv
// Directed bench for reverse_bits_scheduler at default parameters.
module tb_reverse_bits_scheduler;
  logic clk;
  logic rst_n;
  logic busy;
  logic [31:0] words [4];
  int checks;
  int errors;
  int cyc;

  reverse_bits_if #(.NUM_REQ(4), .DATA_W(32), .ID_W(2)) bus ();

  reverse_bits_scheduler #(
    .NUM_REQ(4), .DATA_W(32), .BITS_PER_CYCLE(4), .ID_W(2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus),
    .busy (busy)
  );

  assign bus.req_data = {words[3], words[2], words[1], words[0]};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Raise a request; wait for its one-hot ready, then let the accepting edge pass
  task automatic request(input int id, input logic [31:0] w);
    int n;
    words[2'(id)] = w;
    bus.req_valid = bus.req_valid | 4'(1 << id);
    n = 0;
    #1;
    while ((bus.req_ready & 4'(1 << id)) == 4'b0 && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("grant_onehot", 32'(bus.req_ready), 32'(1 << id));
    @(posedge clk);
    #1;
    bus.req_valid = bus.req_valid & ~4'(1 << id);
  endtask

  // Called right after the accepting edge; checks latency, fields, stalls, handshake
  task automatic expect_rsp(input string tag, input logic [31:0] data, input logic pal,
                            input int id, input int hold);
    int lat;
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (!bus.rsp_valid && lat < 40);
    check({tag, "_lat"}, 32'(lat), 32'd8);
    check({tag, "_data"}, bus.rsp_data, data);
    check({tag, "_pal"}, 32'(bus.rsp_palindrome), 32'(pal));
    check({tag, "_id"}, 32'(bus.rsp_id), 32'(id));
    check({tag, "_busy"}, 32'(busy), 32'd1);
    repeat (hold) begin
      @(negedge clk);
      check({tag, "_hold_valid"}, 32'(bus.rsp_valid), 32'd1);
      check({tag, "_hold_data"}, bus.rsp_data, data);
      check({tag, "_hold_ready"}, 32'(bus.req_ready), 32'd0);
      check({tag, "_hold_busy"}, 32'(busy), 32'd1);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    check({tag, "_after_valid"}, 32'(bus.rsp_valid), 32'd0);
    check({tag, "_after_data"}, bus.rsp_data, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    int prev;
    logic [31:0] exp_rot [4];
    checks = 0;
    errors = 0;
    cyc = 0;
    rst_n = 1'b0;
    bus.req_valid = '0;
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) words[i] = '0;
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_data", bus.rsp_data, 32'd0);
    check("rst_id", 32'(bus.rsp_id), 32'd0);
    check("rst_ready", 32'(bus.req_ready), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single job from requester 0
    request(0, 32'h0000_0001);
    expect_rsp("t1", 32'h8000_0000, 1'b0, 0, 0);

    // Requester 2 back to back: two palindromes then a plain word
    request(2, 32'h8000_0001);
    expect_rsp("t2a", 32'h8000_0001, 1'b1, 2, 0);
    request(2, 32'hF00F_F00F);
    expect_rsp("t2b", 32'hF00F_F00F, 1'b1, 2, 0);
    request(2, 32'h1234_5678);
    expect_rsp("t2c", 32'h1E6A_2C48, 1'b0, 2, 0);

    // rr_ptr now 3: requests on 0 and 1 wrap to 0 first; stall DONE 5 cycles
    words[1] = 32'h0000_FFFF;
    bus.req_valid = 4'b0010;
    request(0, 32'hA5A5_A5A5);
    expect_rsp("t5a", 32'hA5A5_A5A5, 1'b1, 0, 5);
    request(1, 32'h0000_FFFF);
    expect_rsp("t5b", 32'hFFFF_0000, 1'b0, 1, 0);

    // All requesters asserted from reset with rsp_ready held high
    rst_n = 1'b0;
    words[0] = 32'h0000_0001; exp_rot[0] = 32'h8000_0000;
    words[1] = 32'h0000_0003; exp_rot[1] = 32'hC000_0000;
    words[2] = 32'h0000_000F; exp_rot[2] = 32'hF000_0000;
    words[3] = 32'h0000_00FF; exp_rot[3] = 32'hFF00_0000;
    bus.req_valid = 4'hF;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    prev = 0;
    for (int g = 0; g < 5; g++) begin
      n = 0;
      while (bus.req_ready == 4'b0 && n < 50) begin
        @(negedge clk);
        #1;
        n++;
      end
      check("rot_grant", 32'(bus.req_ready), 32'(1 << (g % 4)));
      if (g > 0) check("rot_period", 32'(cyc - prev), 32'd10);
      prev = cyc;
      @(negedge clk);
      #1;
      check("rot_pulse", 32'(bus.req_ready), 32'd0);
      n = 0;
      while (!bus.rsp_valid && n < 50) begin
        @(negedge clk);
        #1;
        n++;
      end
      check("rot_valid", 32'(bus.rsp_valid), 32'd1);
      check("rot_id", 32'(bus.rsp_id), 32'(g % 4));
      check("rot_data", bus.rsp_data, exp_rot[g % 4]);
      if (g == 4) bus.req_valid = '0;
      @(negedge clk);
      #1;
    end
    bus.rsp_ready = 1'b0;
    @(negedge clk);

    // Reset during the 4th BUSY cycle drops the job
    request(3, 32'h1234_5678);
    repeat (3) @(posedge clk);
    #1;
    check("t6_busy_before", 32'(busy), 32'd1);
    check("t6_data_busy", bus.rsp_data, 32'd0);
    rst_n = 1'b0;
    #1;
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_valid", 32'(bus.rsp_valid), 32'd0);
    check("t6_rst_data", bus.rsp_data, 32'd0);
    check("t6_rst_ready", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("t6_no_rsp", 32'(bus.rsp_valid), 32'd0);
    request(1, 32'hFFFF_0000);
    expect_rsp("t6", 32'h0000_FFFF, 1'b0, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reverse_bits_scheduler.md
Name: reverse_bits_scheduler

Overview:
Shares one iterative bit-reversal/palindrome engine between NUM_REQ requesters. Uses a round-robin arbiter and a small sequencing FSM.
Each accepted 32-bit word is reversed over several cycles, BITS_PER_CYCLE bits per cycle. The result, a palindrome flag and the requester id are returned on a single valid/ready response channel.
Sits between client blocks needing bit reversal and the shared reversal datapath, replacing per-client combinational reversers.

Parameters:
NUM_REQ, 4, number of requesters (>=1)
DATA_W, 32, word width
BITS_PER_CYCLE, 4, bits reversed per engine cycle; DATA_W % BITS_PER_CYCLE == 0 (elaboration-time assertion)
ID_W, $clog2(NUM_REQ) (min 1), width of requester id

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester request valid
req_data  in  NUM_REQ*DATA_W  per-requester word, packed; slice i belongs to requester i
req_ready  out  NUM_REQ  one-hot accept strobe
rsp_valid  out  1  result valid
rsp_ready  in  1  consumer ready
rsp_data  out  DATA_W  bit-reversed word
rsp_palindrome  out  1  1 when the captured word equals its reversal
rsp_id  out  ID_W  index of the requester served
busy  out  1  high in BUSY or DONE

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset values:
  - state=IDLE, rr_ptr=0, step counter=0.
  - Captured word, shift register and result cleared to 0.
  - Outputs: rsp_valid=0, rsp_data=0, rsp_palindrome=0, rsp_id=0, busy=0, req_ready=0.
- Definitions: STEPS = DATA_W/BITS_PER_CYCLE (8 at defaults). Handshake occurs when valid&ready at a rising edge.
- FSM states:
  - IDLE: req_ready is combinational from req_valid and rr_ptr, non-zero only in IDLE. It selects the first asserted req_valid scanning rr_ptr, rr_ptr+1, ..., wrapping mod NUM_REQ.
    - On grant g: capture req_data[g] and g; rr_ptr<=(g+1) mod NUM_REQ; counter<=0; go BUSY.
    - With no requests: stay in IDLE; rr_ptr unchanged.
  - BUSY: each cycle the engine moves BITS_PER_CYCLE LSBs of the remaining source into the result, MSB-first, and increments the counter.
    - After the STEPS-th BUSY cycle, go DONE.
    - Latency: rsp_valid is high STEPS cycles after the accepting edge.
  - DONE: rsp_valid=1. rsp_data, rsp_palindrome and rsp_id are held stable until rsp_ready; on the handshake edge go IDLE.
    - A new request is not accepted on the same edge. Minimum period is therefore STEPS+2 cycles per word.
- Datapath:
  - rsp_palindrome = (result == captured word), registered on entry to DONE.
  - rsp_data equals the full-width reversal: bit i = source bit DATA_W-1-i.
  - rsp_data, rsp_palindrome and rsp_id read 0 outside DONE.
- Requester obligations: hold req_data stable while req_valid is high and not yet granted. Dropping req_valid before grant is legal and loses no state.
- Boundary conditions:
  - All requests asserted: strict rotation 0,1,...,NUM_REQ-1,0.
  - NUM_REQ=1: grant whenever valid in IDLE; rr_ptr stays 0.
  - BITS_PER_CYCLE=DATA_W: STEPS=1.
  - rsp_ready held high before DONE: no effect until DONE.
  - Reset mid-BUSY or mid-DONE: job dropped with no response, all state returns to reset values immediately.
- Counter width is $clog2(STEPS+1); it never wraps.

Decomposition:
- Package reverse_bits_pkg: state enum (IDLE, BUSY, DONE), default DATA_W constant, and a function computing STEPS.
- Sub-module reverse_bits_engine: holds the shift register, step counter and palindrome compare. Interface: start, src, done, result, palindrome.
- Arbiter and FSM stay in the top module.

Test Plan:
1. Defaults; requester 0 sends 32'h0000_0001 -> requester 1 of reset-zeroed... see corrected cases below; expected rsp_data=32'h8000_0000, rsp_palindrome=0, rsp_id=0, rsp_valid 8 cycles after accept.
   Corrected stimulus: requester 0 sends 32'h0000_0001 -> rsp_data=32'h8000_0000, rsp_palindrome=0, rsp_id=0, rsp_valid 8 cycles after accept.
2. Requester 2 sends 32'h8000_0001, then 32'hF00F_F00F, then 32'h1234_5678 -> rsp_palindrome=1, 1, 0; third rsp_data=32'h1E6A_2C48.
3. All four req_valid high from reset, rsp_ready=1 -> grants/rsp_id sequence 0,1,2,3,0; each one-hot req_ready pulses once per grant; period 10 cycles.
4. rsp_ready low for 5 cycles in DONE -> rsp_* stable, busy=1, req_ready all 0; on release one handshake, then next grant.
5. rr_ptr=3 with requests on 0 and 1 -> grant 0 (wrap), rr_ptr becomes 1, then grant 1.
6. rst_n low at the 4th BUSY cycle -> all outputs 0 immediately (asynchronous); after release, requester 1 sends 32'hFFFF_0000 -> rsp_data=32'h0000_FFFF, rsp_id=1, correct latency.
